// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FWFT FIFO controller: output stage occupancy
// encoding and the width of the level counter.
package fifo_ctrl_pkg;

    // Number of entries held in the head/skid output stage
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Level must count DEPTH memory entries plus one in-flight read plus two
    // stage entries, so it needs two bits more than the address.
    function automatic int level_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ostage.sv
// Two-entry output stage (head + skid) fed by memory read returns.
// Items are ordered head first, then skid, then any data returning this cycle.
module fifo_ctrl_ostage
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  pop,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic                  head_valid_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [DATA_WIDTH-1:0] skid_data_r;

    logic head_valid_s;
    logic skid_valid_s;
    logic head_load_s;
    logic head_from_skid_s;
    logic skid_load_s;

    // Next-state of the stage: apply the pop first, then place returning data
    // in the first free slot so ordering is preserved.
    always_comb begin
        head_valid_s     = head_valid_r;
        skid_valid_s     = skid_valid_r;
        head_load_s      = 1'b0;
        head_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (pop && skid_valid_r) begin
            head_from_skid_s = 1'b1;
            head_valid_s     = 1'b1;
            skid_valid_s     = fill;
            skid_load_s      = fill;
        end else if (pop) begin
            head_valid_s = fill;
            head_load_s  = fill;
        end else if (fill && !head_valid_r) begin
            head_valid_s = 1'b1;
            head_load_s  = 1'b1;
        end else if (fill) begin
            skid_valid_s = 1'b1;
            skid_load_s  = 1'b1;
        end else begin
            head_valid_s = head_valid_r;
        end
    end

    // Valid bits: flushed by reset or clear, which also drops any return
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            head_valid_r <= head_valid_s;
            skid_valid_r <= skid_valid_s;
        end
    end

    // Payload registers: no reset, qualified by the valid bits
    always_ff @(posedge clk) begin
        if (head_from_skid_s) begin
            head_data_r <= skid_data_r;
        end else if (head_load_s) begin
            head_data_r <= fill_data;
        end else begin
            head_data_r <= head_data_r;
        end
        if (skid_load_s) begin
            skid_data_r <= fill_data;
        end else begin
            skid_data_r <= skid_data_r;
        end
    end

    // Occupancy encoding; skid without head cannot occur
    always_comb begin
        case ({head_valid_r, skid_valid_r})
            2'b00:   occ = OCC_EMPTY;
            2'b10:   occ = OCC_ONE;
            2'b11:   occ = OCC_TWO;
            default: occ = OCC_ONE;
        endcase
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external 1R/1W memory
// with a 1-cycle registered read. Owns pointers, memory occupancy and read
// scheduling; the output stage hides the read latency at full throughput.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [level_width(ADDR_WIDTH)-1:0]   level,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_waddr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic [ADDR_WIDTH-1:0]                mem_raddr,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    localparam int LW = level_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   mem_cnt_r;
    logic                  rd_inflight_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [1:0]            occ_s;
    logic [1:0]            occ_ap_s;
    logic [ADDR_WIDTH:0]   mem_cnt_s;

    // Handshakes; in_ready depends only on registered occupancy
    always_comb begin
        in_ready = (mem_cnt_r != DEPTH_C);
        push_s   = in_valid & in_ready;
        pop_s    = out_valid & out_ready;
        mem_we   = push_s & ~(rst | clr);
    end

    // Read issue: only entries written in an earlier cycle, and only when the
    // stage is guaranteed a free slot for the returning word.
    always_comb begin
        if (pop_s) begin
            occ_ap_s = occ_s - 2'd1;
        end else begin
            occ_ap_s = occ_s;
        end
        issue_s = (mem_cnt_r != {(ADDR_WIDTH+1){1'b0}}) &&
                  ((occ_ap_s + {1'b0, rd_inflight_r}) < OCC_TWO);
    end

    // Memory occupancy: push adds, issue removes, both together cancel
    always_comb begin
        case ({push_s, issue_s})
            2'b10:   mem_cnt_s = mem_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   mem_cnt_s = mem_cnt_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: mem_cnt_s = mem_cnt_r;
        endcase
    end

    // Pointer, count and in-flight state; clear behaves as a reset
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r      <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r      <= {ADDR_WIDTH{1'b0}};
            mem_cnt_r     <= {(ADDR_WIDTH+1){1'b0}};
            rd_inflight_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            mem_cnt_r     <= mem_cnt_s;
            rd_inflight_r <= issue_s;
        end
    end

    fifo_ctrl_ostage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ostage (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .pop        (pop_s),
        .fill       (rd_inflight_r),
        .fill_data  (mem_rdata),
        .head_valid (out_valid),
        .head_data  (out_data),
        .occ        (occ_s)
    );

    // Memory-side ports and total item count
    always_comb begin
        mem_waddr = wr_ptr_r;
        mem_wdata = in_data;
        mem_raddr = rd_ptr_r;
        level     = {1'b0, mem_cnt_r} + LW'(rd_inflight_r) + LW'(occ_s);
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a small behavioural memory beside it.
module tb_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, clr, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, mem_wdata, mem_rdata;
    logic [AW+1:0] level;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    // Memory model: registered read, old data on same-address read-during-write
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    typedef struct {
        logic          rst, clr, iv;
        logic [DW-1:0] id;
        logic          ordy, chk, e_ir, e_ov;
        logic [DW-1:0] e_od;
        logic [AW+1:0] e_lvl;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic r, c, iv, input logic [DW-1:0] id,
                                input logic ordy, chk, e_ir, e_ov,
                                input logic [DW-1:0] e_od, input logic [AW+1:0] e_lvl);
        vec_t v;
        v.rst = r; v.clr = c; v.iv = iv; v.id = id; v.ordy = ordy; v.chk = chk;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, c, iv, input logic [DW-1:0] id, input logic ordy);
        @(negedge clk);
        rst = r; clr = c; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
    endtask

    initial begin
        logic [DW-1:0] q [$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] seq;
        int            next_idx;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Reset, single-item latency, then fill with out_ready low (DEPTH=4)
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd2);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 4'd3);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 4'd4);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 4'd5);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 4'd6);
        // Full: pop and push offered together, push refused
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 8'h16, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 4'd6);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 8'h16, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 4'd5);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 4'd5);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 4'd4);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 4'd3);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 4'd2);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 4'd1);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
                check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
                check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
                if (vecs[i].e_ov)
                    check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            end
        end

        // Streaming across pointer wrap: item k appears at cycle k+3, no bubbles
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + c), 1'b1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (c >= 3) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(8'h40 + c - 3));
            end
        end
        next_idx = 17;
        for (int c = 0; c < 10 && next_idx < 20; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                check("stream_drain_data", 32'(out_data), 32'(8'h40 + next_idx));
                next_idx++;
            end
        end
        check("stream_drain_count", 32'(next_idx), 32'd20);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("stream_empty_level", 32'(level), 32'd0);

        // Clear with a read in flight and the stage occupied
        drive(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'hA3, 1'b0);
        check("clr_pre_level", 32'(level), 32'd3);
        check("clr_pre_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_level", 32'(level), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("clr_late_valid", 32'(out_valid), 32'd0);
        check("clr_late_level", 32'(level), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'hAB, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("post_clr_t1_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("post_clr_t2_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_clr_t3_valid", 32'(out_valid), 32'd1);
        check("post_clr_t3_data", 32'(out_data), 32'hAB);

        // Random handshakes against a queue scoreboard
        seq = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), seq, 1'($urandom_range(0, 1)));
            check("rand_level", 32'(level), 32'(q.size()));
            if (!in_ready)
                check("rand_full_needs_level", 32'(q.size() >= 4), 32'd1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_pop_nonempty", 32'd0, 32'd1);
                end else begin
                    exp_d = q.pop_front();
                    check("rand_data", 32'(out_data), 32'(exp_d));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                seq = seq + 8'd1;
            end
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                exp_d = q.pop_front();
                check("drain_data", 32'(out_data), 32'(exp_d));
            end
        end
        check("drain_model_empty", 32'(q.size()), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("drain_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
